// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle main controller: states, opcodes, Funct
// codes, ALU controls, datapath select codes and the per-state control word.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_INWB    = 4'd12,
        S_JALEX   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_IN    = 6'h3F;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // ALUOP_NONE is for states that leave the ALU idle (control reads 000).
    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_FUNCT = 2'b11
    } alu_op_t;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] GPIO_SEL_MEM = 2'b00;
    localparam logic [1:0] GPIO_SEL_IN  = 2'b01;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] gpio_sel;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
    } ctrl_t;

    // Moore control word for a state; alu_control is filled in by the ALU decoder.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_src    = PCSRC_ALU;
            end
            S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = 1'b1;
                c.gpio_sel   = GPIO_SEL_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
            end
            S_RTYPEWB: begin
                c.reg_dst   = REGDST_RD;
                c.reg_write = 1'b1;
            end
            S_BEQEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                c.reg_dst   = REGDST_RT;
                c.reg_write = 1'b1;
            end
            S_JEX: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            S_JALEX: begin
                c.pc_src    = PCSRC_JUMP;
                c.pc_write  = 1'b1;
                c.reg_dst   = REGDST_RA;
                c.reg_write = 1'b1;
            end
            S_INWB: begin
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = 1'b1;
                c.gpio_sel   = GPIO_SEL_IN;
                c.reg_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic alu_op_t state_alu_op(input state_t s);
        case (s)
            S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: return ALUOP_ADD;
            S_BEQEX:                               return ALUOP_SUB;
            S_RTYPEEX:                             return ALUOP_FUNCT;
            default:                               return ALUOP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps the controller's ALUOp and the R-type Funct field to an
// ALUControl code, flagging Funct values the datapath does not implement.
module multicycle_control_fsm_alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_bad
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        alu_control = ALU_IDLE;
        funct_bad   = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default: begin
                        alu_control = ALU_ADD;
                        funct_bad   = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the 32-bit multicycle datapath. The control word
// for the next state is registered with the state; reset masks every output.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned GPIO_IN_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] gpio_i,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl_q;
    ctrl_t      nxt_ctrl;
    alu_op_t    nxt_alu_op;
    logic [2:0] nxt_alu_control;
    logic       nxt_funct_bad;
    logic       funct_bad_q;
    logic       is_sw_q;

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    OP_JAL:       next_state = S_JALEX;
                    OP_IN:        next_state = (GPIO_IN_EN != 0) ? S_INWB : S_FETCH;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = S_MEMWB;
            S_RTYPEEX: next_state = S_RTYPEWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    assign nxt_alu_op = state_alu_op(next_state);

    multicycle_control_fsm_alu_decoder u_alu_decoder (
        .alu_op      (nxt_alu_op),
        .funct       (Funct),
        .alu_control (nxt_alu_control),
        .funct_bad   (nxt_funct_bad)
    );

    // An unsupported Funct seen on entry to RTYPEEX cancels the RTYPEWB write.
    always_comb begin
        nxt_ctrl             = state_ctrl(next_state);
        nxt_ctrl.alu_control = nxt_alu_control;
        if (next_state == S_RTYPEWB && funct_bad_q) begin
            nxt_ctrl.reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state uses non-blocking assignments so every register in
            // this block sees the pre-edge values, independent of statement order.
            state                <= S_FETCH;
            ctrl_q               <= state_ctrl(S_FETCH);
            ctrl_q.alu_control   <= ALU_ADD;
            funct_bad_q          <= 1'b0;
            is_sw_q              <= 1'b0;
        end else begin
            state  <= next_state;
            ctrl_q <= nxt_ctrl;
            if (state == S_DECODE) begin
                is_sw_q <= (Op == OP_SW);
            end
            if (next_state == S_RTYPEEX) begin
                funct_bad_q <= nxt_funct_bad;
            end
        end
    end

    // Branch-taken is the only combinational term: Zero is live during BEQEX.
    assign PCWrite    = reset & (ctrl_q.pc_write | (ctrl_q.branch & Zero));
    assign PCSrc      = reset ? ctrl_q.pc_src      : 2'b00;
    assign RegWrite   = reset & ctrl_q.reg_write;
    assign IorD       = reset & ctrl_q.iord;
    assign MemWrite   = reset & ctrl_q.mem_write;
    assign IRWrite    = reset & ctrl_q.ir_write;
    assign RegDst     = reset ? ctrl_q.reg_dst     : 2'b00;
    assign MemtoReg   = reset & ctrl_q.mem_to_reg;
    assign ALUSrcA    = reset & ctrl_q.alu_src_a;
    assign gpio_i     = reset ? ctrl_q.gpio_sel    : 2'b00;
    assign ALUSrcB    = reset ? ctrl_q.alu_src_b   : 2'b00;
    assign ALUControl = reset ? ctrl_q.alu_control : 3'b000;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multicycle controller: stimulus pushes the expected
// state and control word per cycle, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;

    logic       pcw_a, rw_a, iord_a, mw_a, irw_a, m2r_a, srca_a;
    logic [1:0] pcsrc_a, regdst_a, gpio_a, srcb_a;
    logic [2:0] aluc_a;
    logic [3:0] st_a;
    logic       pcw_b, rw_b, iord_b, mw_b, irw_b, m2r_b, srca_b;
    logic [1:0] pcsrc_b, regdst_b, gpio_b, srcb_b;
    logic [2:0] aluc_b;
    logic [3:0] st_b;

    multicycle_control_fsm #(.GPIO_IN_EN(1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(pcw_a), .PCSrc(pcsrc_a), .RegWrite(rw_a), .IorD(iord_a),
        .MemWrite(mw_a), .IRWrite(irw_a), .RegDst(regdst_a), .MemtoReg(m2r_a),
        .ALUSrcA(srca_a), .gpio_i(gpio_a), .ALUSrcB(srcb_a),
        .ALUControl(aluc_a), .state_o(st_a)
    );

    multicycle_control_fsm #(.GPIO_IN_EN(0)) dut_nogpio (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(pcw_b), .PCSrc(pcsrc_b), .RegWrite(rw_b), .IorD(iord_b),
        .MemWrite(mw_b), .IRWrite(irw_b), .RegDst(regdst_b), .MemtoReg(m2r_b),
        .ALUSrcA(srca_b), .gpio_i(gpio_b), .ALUSrcB(srcb_b),
        .ALUControl(aluc_b), .state_o(st_b)
    );

    always #5 clk = ~clk;

    // Word order: PCWrite PCSrc RegWrite IorD MemWrite IRWrite RegDst MemtoReg ALUSrcA gpio_i ALUSrcB ALUControl
    logic [17:0] w_a, w_b;
    assign w_a = {pcw_a, pcsrc_a, rw_a, iord_a, mw_a, irw_a, regdst_a, m2r_a, srca_a, gpio_a, srcb_a, aluc_a};
    assign w_b = {pcw_b, pcsrc_b, rw_b, iord_b, mw_b, irw_b, regdst_b, m2r_b, srca_b, gpio_b, srcb_b, aluc_b};

    function automatic logic [17:0] mk(input logic pcw, input logic [1:0] pcsrc,
                                       input logic rw, input logic iord, input logic mw,
                                       input logic irw, input logic [1:0] regdst,
                                       input logic m2r, input logic srca,
                                       input logic [1:0] gpio, input logic [1:0] srcb,
                                       input logic [2:0] aluc);
        return {pcw, pcsrc, rw, iord, mw, irw, regdst, m2r, srca, gpio, srcb, aluc};
    endfunction

    localparam logic [17:0] W_RST    = 18'h0;
    localparam logic [17:0] W_FETCH  = mk(1, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 2'b01, 3'b010);
    localparam logic [17:0] W_DECODE = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11, 3'b010);
    localparam logic [17:0] W_MEMADR = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b10, 3'b010);
    localparam logic [17:0] W_MEMRD  = mk(0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 3'b000);
    localparam logic [17:0] W_MEMWB  = mk(0, 2'b00, 1, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 3'b000);
    localparam logic [17:0] W_MEMWR  = mk(0, 2'b00, 0, 1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 3'b000);
    localparam logic [17:0] W_ADDIEX = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b10, 3'b010);
    localparam logic [17:0] W_ADDIWB = mk(0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 3'b000);
    localparam logic [17:0] W_JEX    = mk(1, 2'b10, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 3'b000);
    localparam logic [17:0] W_JALEX  = mk(1, 2'b10, 1, 0, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 3'b000);
    localparam logic [17:0] W_INWB   = mk(0, 2'b00, 1, 0, 0, 0, 2'b00, 1, 0, 2'b01, 2'b00, 3'b000);

    function automatic logic [17:0] w_rex(input logic [2:0] aluc);
        return mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, aluc);
    endfunction
    function automatic logic [17:0] w_rwb(input logic rw);
        return mk(0, 2'b00, rw, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [17:0] w_beq(input logic z);
        return mk(z, 2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 3'b110);
    endfunction

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [17:0] w;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got state/ctrl=%06h, want %06h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(e.name, {10'd0, st_a, w_a}, {10'd0, e.st, e.w});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check({"nogpio ", e.name}, {10'd0, st_b, w_b}, {10'd0, e.st, e.w});
        end
    end

    task automatic expect_b(input string name, input logic [3:0] st, input logic [17:0] w);
        exp_t e;
        e.name = name; e.st = st; e.w = w;
        q1.push_back(e);
    endtask

    // Drive one cycle of inputs, queue the main DUT's expectation, advance.
    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic [5:0] funct, input logic z,
                        input logic [3:0] st, input logic [17:0] w);
        exp_t e;
        reset = rst; Op = op; Funct = funct; Zero = z;
        e.name = name; e.st = st; e.w = w;
        q0.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; Op = 6'h00; Funct = 6'h00; Zero = 1'b0;
        @(posedge clk);
        #1;
        step("reset hold 0", 0, 6'h00, 6'h00, 0, 4'd0, W_RST);
        step("reset hold 1", 0, 6'h00, 6'h00, 0, 4'd0, W_RST);

        step("lw fetch after release", 1, 6'h23, 6'h00, 0, 4'd0, W_FETCH);
        step("lw decode",  1, 6'h23, 6'h00, 0, 4'd1, W_DECODE);
        step("lw memadr",  1, 6'h23, 6'h00, 0, 4'd2, W_MEMADR);
        step("lw memrd",   1, 6'h23, 6'h00, 0, 4'd3, W_MEMRD);
        step("lw memwb",   1, 6'h23, 6'h00, 0, 4'd4, W_MEMWB);

        step("sw fetch",   1, 6'h2B, 6'h00, 0, 4'd0, W_FETCH);
        step("sw decode",  1, 6'h2B, 6'h00, 0, 4'd1, W_DECODE);
        step("sw memadr",  1, 6'h2B, 6'h00, 0, 4'd2, W_MEMADR);
        step("sw memwr",   1, 6'h2B, 6'h00, 0, 4'd5, W_MEMWR);

        step("slt fetch",  1, 6'h00, 6'h2A, 0, 4'd0, W_FETCH);
        step("slt decode", 1, 6'h00, 6'h2A, 0, 4'd1, W_DECODE);
        step("slt ex",     1, 6'h00, 6'h2A, 0, 4'd6, w_rex(3'b111));
        step("slt wb",     1, 6'h00, 6'h2A, 0, 4'd7, w_rwb(1));
        step("sub fetch",  1, 6'h00, 6'h22, 0, 4'd0, W_FETCH);
        step("sub decode", 1, 6'h00, 6'h22, 0, 4'd1, W_DECODE);
        step("sub ex",     1, 6'h00, 6'h22, 0, 4'd6, w_rex(3'b110));
        step("sub wb",     1, 6'h00, 6'h22, 0, 4'd7, w_rwb(1));
        step("bad fetch",  1, 6'h00, 6'h3F, 0, 4'd0, W_FETCH);
        step("bad decode", 1, 6'h00, 6'h3F, 0, 4'd1, W_DECODE);
        step("bad ex",     1, 6'h00, 6'h3F, 0, 4'd6, w_rex(3'b010));
        step("bad wb",     1, 6'h00, 6'h3F, 0, 4'd7, w_rwb(0));
        step("and fetch",  1, 6'h00, 6'h24, 0, 4'd0, W_FETCH);
        step("and decode", 1, 6'h00, 6'h24, 0, 4'd1, W_DECODE);
        step("and ex",     1, 6'h00, 6'h24, 0, 4'd6, w_rex(3'b000));
        step("and wb",     1, 6'h00, 6'h24, 0, 4'd7, w_rwb(1));
        step("or fetch",   1, 6'h00, 6'h25, 0, 4'd0, W_FETCH);
        step("or decode",  1, 6'h00, 6'h25, 0, 4'd1, W_DECODE);
        step("or ex",      1, 6'h00, 6'h25, 0, 4'd6, w_rex(3'b001));
        step("or wb",      1, 6'h00, 6'h25, 0, 4'd7, w_rwb(1));

        step("beq taken fetch",  1, 6'h04, 6'h00, 1, 4'd0, W_FETCH);
        step("beq taken decode", 1, 6'h04, 6'h00, 1, 4'd1, W_DECODE);
        step("beq taken ex",     1, 6'h04, 6'h00, 1, 4'd8, w_beq(1));
        step("beq not fetch",    1, 6'h04, 6'h00, 0, 4'd0, W_FETCH);
        step("beq not decode",   1, 6'h04, 6'h00, 1, 4'd1, W_DECODE);
        step("beq not ex",       1, 6'h04, 6'h00, 0, 4'd8, w_beq(0));

        step("addi fetch",  1, 6'h08, 6'h00, 0, 4'd0,  W_FETCH);
        step("addi decode", 1, 6'h08, 6'h00, 0, 4'd1,  W_DECODE);
        step("addi ex",     1, 6'h08, 6'h00, 0, 4'd9,  W_ADDIEX);
        step("addi wb",     1, 6'h08, 6'h00, 0, 4'd10, W_ADDIWB);
        step("j fetch",     1, 6'h02, 6'h00, 0, 4'd0,  W_FETCH);
        step("j decode",    1, 6'h02, 6'h00, 0, 4'd1,  W_DECODE);
        step("j ex",        1, 6'h02, 6'h00, 0, 4'd11, W_JEX);
        step("jal fetch",   1, 6'h03, 6'h00, 0, 4'd0,  W_FETCH);
        step("jal decode",  1, 6'h03, 6'h00, 0, 4'd1,  W_DECODE);
        step("jal ex",      1, 6'h03, 6'h00, 0, 4'd13, W_JALEX);
        step("undef fetch", 1, 6'h11, 6'h00, 0, 4'd0,  W_FETCH);
        step("undef decode",1, 6'h11, 6'h00, 0, 4'd1,  W_DECODE);

        // Both instances are in lockstep up to here; Op 3F splits them.
        expect_b("in fetch", 4'd0, W_FETCH);
        step("in fetch",    1, 6'h3F, 6'h00, 0, 4'd0,  W_FETCH);
        expect_b("in decode", 4'd1, W_DECODE);
        step("in decode",   1, 6'h3F, 6'h00, 0, 4'd1,  W_DECODE);
        expect_b("in back to fetch", 4'd0, W_FETCH);
        step("in wb",       1, 6'h3F, 6'h00, 0, 4'd12, W_INWB);

        step("sw2 fetch",   1, 6'h2B, 6'h00, 0, 4'd0,  W_FETCH);
        step("sw2 decode",  1, 6'h2B, 6'h00, 0, 4'd1,  W_DECODE);
        step("sw2 memadr",  1, 6'h2B, 6'h00, 0, 4'd2,  W_MEMADR);
        step("reset in memwr", 0, 6'h2B, 6'h00, 0, 4'd0, W_RST);
        step("reset cycle 2",  0, 6'h2B, 6'h00, 0, 4'd0, W_RST);
        step("reset cycle 3",  0, 6'h2B, 6'h00, 0, 4'd0, W_RST);
        expect_b("release fetch", 4'd0, W_FETCH);
        step("release fetch",  1, 6'h23, 6'h00, 0, 4'd0, W_FETCH);
        expect_b("release decode", 4'd1, W_DECODE);
        step("release decode", 1, 6'h23, 6'h00, 0, 4'd1, W_DECODE);
        step("release memadr", 1, 6'h23, 6'h00, 0, 4'd2, W_MEMADR);

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
